// File: rtl/spm_seq_mul.sv
`default_nettype none
// ============================================================================
// Module : spm_seq_mul
// Brief  : Serial-parallel carry-save multiplier; parallel x, serial y (LSB
//          first), serial and held parallel 2*WIDTH-bit product.
// Rev    : 1.0
// ============================================================================
module spm_seq_mul #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic                 y,
    output logic                 busy,
    output logic                 p,
    output logic                 p_valid,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_CNT_W  = $clog2(2 * WIDTH);
    localparam logic [c_CNT_W-1:0] c_Y_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(2 * WIDTH - 1);

    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:1]   r_s;
    logic [WIDTH-1:0]   r_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ysign;
    logic [2*WIDTH-2:0] r_sreg;
    logic               r_busy;
    logic               r_p;
    logic               r_p_valid;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic               w_yb;
    logic [WIDTH-1:0]   w_pp;
    logic [WIDTH-1:0]   w_sin;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_cry;

    assign w_yb = (r_cnt <= c_Y_LAST) ? y : (SIGNED & r_ysign);

    // Signed mode: the MSB cell adds the inverted partial product, and a single
    // 2^(WIDTH-1) injected in cycle 0 cancels the accumulated inversion offsets
    // modulo 2^(2*WIDTH), so every cell input stays non-negative and exact.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i < WIDTH - 1) begin : g_mid
            assign w_pp[i]  = r_x[i] & w_yb;
            assign w_sin[i] = r_s[i+1];
        end else begin : g_top
            assign w_pp[i]  = SIGNED ? ~(r_x[i] & w_yb) : (r_x[i] & w_yb);
            assign w_sin[i] = SIGNED & (r_cnt == '0);
        end
        assign w_sum[i] = w_pp[i] ^ w_sin[i] ^ r_c[i];
        assign w_cry[i] = (w_pp[i] & w_sin[i]) | (w_pp[i] & r_c[i]) | (w_sin[i] & r_c[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x       <= '0;
            r_s       <= '0;
            r_c       <= '0;
            r_cnt     <= '0;
            r_ysign   <= 1'b0;
            r_sreg    <= '0;
            r_busy    <= 1'b0;
            r_p       <= 1'b0;
            r_p_valid <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                r_p       <= 1'b0;
                r_p_valid <= 1'b0;
                if (start) begin
                    r_x    <= x;
                    r_s    <= '0;
                    r_c    <= '0;
                    r_sreg <= '0;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
            end else begin
                r_p       <= w_sum[0];
                r_p_valid <= 1'b1;
                r_sreg    <= {w_sum[0], r_sreg[2*WIDTH-2:1]};
                r_s       <= w_sum[WIDTH-1:1];
                r_c       <= w_cry;
                if (r_cnt == c_Y_LAST) begin
                    r_ysign <= y;
                end
                if (r_cnt == c_LAST) begin
                    // Residual carry-save state is beyond 2^(2*WIDTH); drop it.
                    r_product <= {w_sum[0], r_sreg};
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_s       <= '0;
                    r_c       <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign p       = r_p;
    assign p_valid = r_p_valid;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_spm_seq_mul.sv
`default_nettype none
// ============================================================================
// Module : tb_spm_seq_mul
// Brief  : Scoreboard bench for spm_seq_mul (WIDTH=8), unsigned and signed
//          instances driven with identical stimulus.
// Rev    : 1.0
// ============================================================================
module tb_spm_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x = '0;
    logic        y = 1'b0;

    logic [1:0]  busy_w;
    logic [1:0]  p_w;
    logic [1:0]  p_valid_w;
    logic [1:0]  done_w;
    logic [15:0] prod_w [2];

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];

    int          run    [2];
    int          bitcnt [2];
    logic [15:0] acc    [2];
    logic [15:0] last   [2];
    logic        prev_acc [2];

    always #5 clk = ~clk;

    spm_seq_mul #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy_w[0]), .p(p_w[0]), .p_valid(p_valid_w[0]),
        .done(done_w[0]), .product(prod_w[0])
    );

    spm_seq_mul #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy_w[1]), .p(p_w[1]), .p_valid(p_valid_w[1]),
        .done(done_w[1]), .product(prod_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit s);
        logic signed [15:0] sa, sb;
        sa = s ? {{8{a[7]}}, a} : {8'h00, a};
        sb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return 16'(sa * sb);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge with the DUT idle or in its done cycle;
    // returns in the done cycle of the issued operation.
    task automatic do_op(input logic [7:0] xv, input logic [7:0] yv,
                         input logic [15:0] eu, input logic [15:0] es,
                         input bit hold, input bit intrude);
        start = 1'b1;
        x     = xv;
        exp_q0.push_back(eu);
        exp_q1.push_back(es);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        x = 8'($urandom);
        for (int c = 0; c < 16; c++) begin
            y = (c < 8) ? yv[c] : 1'($urandom);
            if (intrude && c == 5) begin
                start = 1'b1;
                x     = 8'h55;
            end
            if (intrude && c == 6) start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the expected product on every done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                run[k]      = 0;
                bitcnt[k]   = 0;
                acc[k]      = '0;
                last[k]     = '0;
                prev_acc[k] = 1'b0;
            end else begin
                logic [15:0] e;
                if (prev_acc[k]) chk($sformatf("start_to_busy[%0d]", k), 32'(busy_w[k]), 32'd1);
                prev_acc[k] = start && !busy_w[k];
                if (p_valid_w[k]) begin
                    if (bitcnt[k] < 16) acc[k][bitcnt[k]] = p_w[k];
                    bitcnt[k]++;
                end
                if (busy_w[k]) run[k]++;
                if (done_w[k]) begin
                    e = '0;
                    if (k == 0) begin
                        chk("done_has_pending[0]", 32'(exp_q0.size() != 0), 32'd1);
                        if (exp_q0.size() != 0) e = exp_q0.pop_front();
                    end else begin
                        chk("done_has_pending[1]", 32'(exp_q1.size() != 0), 32'd1);
                        if (exp_q1.size() != 0) e = exp_q1.pop_front();
                    end
                    chk($sformatf("product[%0d]", k), 32'(prod_w[k]), 32'(e));
                    chk($sformatf("p_stream[%0d]", k), 32'(acc[k]), 32'(e));
                    chk($sformatf("p_count[%0d]", k), 32'(bitcnt[k]), 32'd16);
                    chk($sformatf("busy_run[%0d]", k), 32'(run[k]), 32'd16);
                    last[k]   = e;
                    acc[k]    = '0;
                    bitcnt[k] = 0;
                end else begin
                    chk($sformatf("product_hold[%0d]", k), 32'(prod_w[k]), 32'(last[k]));
                end
                if (!busy_w[k]) run[k] = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] xv, yv;
        idle(2);
        chk("rst_busy",    32'(busy_w),    32'd0);
        chk("rst_p",       32'(p_w),       32'd0);
        chk("rst_p_valid", 32'(p_valid_w), 32'd0);
        chk("rst_done",    32'(done_w),    32'd0);
        chk("rst_product", {prod_w[0], prod_w[1]}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Unsigned max / signed corners (expected: unsigned, signed).
        do_op(8'hFF, 8'hFF, 16'hFE01, 16'h0001, 1'b0, 1'b0);
        idle(2);
        do_op(8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 16'h00FF, 16'hFFFF, 1'b0, 1'b0);
        do_op(8'h7F, 8'h80, 16'h3F80, 16'hC080, 1'b0, 1'b0);
        idle(1);

        // Start while busy with a different x.
        do_op(8'h12, 8'h34, 16'h03A8, 16'h03A8, 1'b0, 1'b1);
        idle(3);

        // Back-to-back with start held through A's done cycle.
        do_op(8'd3, 8'd5, 16'h000F, 16'h000F, 1'b1, 1'b0);
        do_op(8'd7, 8'd9, 16'h003F, 16'h003F, 1'b0, 1'b0);
        idle(2);

        // Reset mid-operation, asserted between edges in cycle 6.
        start = 1'b1;
        x     = 8'hAB;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            y = 1'($urandom);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy",    32'(busy_w),    32'd0);
        chk("midrst_p",       32'(p_w),       32'd0);
        chk("midrst_p_valid", 32'(p_valid_w), 32'd0);
        chk("midrst_done",    32'(done_w),    32'd0);
        chk("midrst_product", {prod_w[0], prod_w[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        do_op(8'd2, 8'd3, 16'h0006, 16'h0006, 1'b0, 1'b0);
        idle(2);

        // Random regression, back-to-back.
        for (int n = 0; n < 1000; n++) begin
            xv = 8'($urandom);
            yv = 8'($urandom);
            do_op(xv, yv, ref_mul(xv, yv, 1'b0), ref_mul(xv, yv, 1'b1), 1'b0, 1'b0);
        end
        idle(4);

        chk("pending_left[0]", 32'(exp_q0.size()), 32'd0);
        chk("pending_left[1]", 32'(exp_q1.size()), 32'd0);
        chk("stray_p_valid[0]", 32'(bitcnt[0]), 32'd0);
        chk("stray_p_valid[1]", 32'(bitcnt[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
